// File: rtl/seq_detector_n_pkg.sv
// Shared constants and width helpers for the serial pattern detector.
package seq_detector_n_pkg;

   localparam logic MODE_OVL  = 1'b1;
   localparam logic MODE_NOVL = 1'b0;

   // Smallest r such that 2**r >= v.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/dffr_n.sv
// N-bit D register with synchronous active-high reset and load enable.
module dffr_n #(
   parameter int unsigned N = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic [N-1:0] i_d,
   output logic [N-1:0] o_q
);

   logic [N-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst)     r_q <= '0;
      else if (i_en) r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/seq_detector_n.sv
// Serial detector for a runtime-programmable W-bit pattern with progress state,
// overlap/non-overlap restart and a saturating match counter.
module seq_detector_n
   import seq_detector_n_pkg::*;
#(
   parameter int unsigned W  = 4,
   parameter int unsigned CW = 8,
   parameter int unsigned SW = clog2(W + 1)
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          x,
   input  logic          EN,
   input  logic          CLR,
   input  logic          MODE,
   input  logic [W-1:0]  PAT,
   output logic          F,
   output logic [SW-1:0] S,
   output logic [CW-1:0] COUNT
);

   logic [W-1:0]  r_hist;
   logic [SW-1:0] r_fill;
   logic          r_f;

   logic [W-1:0]  w_hist_n;
   logic [SW-1:0] w_fill_n;
   logic          w_match;
   logic          w_accept;
   logic [W:1]    w_pm;
   logic [SW-1:0] w_s_n;
   logic          w_ld;
   logic [W-1:0]  w_hist_d;
   logic [SW-1:0] w_s_d;
   logic          w_cnt_en;

   assign w_accept = EN & ~CLR;
   assign w_hist_n = {r_hist[W-2:0], x};
   assign w_fill_n = (r_fill == SW'(W)) ? SW'(W) : r_fill + SW'(1);
   assign w_match  = (w_fill_n == SW'(W)) && (w_hist_n == PAT);

   // w_pm[k]: the newest k bits equal the first k pattern bits.
   for (genvar k = 1; k <= W; k++) begin : g_pm
      assign w_pm[k] = (w_fill_n >= SW'(k)) && (w_hist_n[k-1:0] == PAT[W-1 -: k]);
   end

   always_comb begin
      w_s_n = '0;
      for (int unsigned k = 1; k <= W; k++) begin
         if (w_pm[k]) w_s_n = SW'(k);
      end
   end

   // CLR loads zeros into hist/S, taking priority over a sample.
   assign w_ld     = EN | CLR;
   assign w_hist_d = CLR ? '0 : w_hist_n;
   assign w_s_d    = CLR ? '0 : w_s_n;
   assign w_cnt_en = w_accept & w_match & ~(&COUNT);

   dffr_n #(.N(W)) u_hist (
      .i_clk (CLK),
      .i_rst (RESET),
      .i_en  (w_ld),
      .i_d   (w_hist_d),
      .o_q   (r_hist)
   );

   dffr_n #(.N(SW)) u_state (
      .i_clk (CLK),
      .i_rst (RESET),
      .i_en  (w_ld),
      .i_d   (w_s_d),
      .o_q   (S)
   );

   dffr_n #(.N(CW)) u_count (
      .i_clk (CLK),
      .i_rst (RESET),
      .i_en  (w_cnt_en),
      .i_d   (COUNT + CW'(1)),
      .o_q   (COUNT)
   );

   // Non-overlap restarts the fill so the next match needs W fresh bits.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_fill <= '0;
         r_f    <= 1'b0;
      end else begin
         r_f <= w_accept & w_match;
         if (CLR)
            r_fill <= '0;
         else if (EN)
            r_fill <= (w_match && (MODE == MODE_NOVL)) ? '0 : w_fill_n;
      end
   end

   assign F = r_f;

endmodule

// File: tb/tb_seq_detector_n.sv
// Self-checking bench: directed scenarios plus random stream against a queue-based model.
module tb_seq_detector_n;

   localparam int unsigned W   = 4;
   localparam int unsigned CW  = 8;
   localparam int unsigned CWS = 2;
   localparam int unsigned SW  = 3;

   logic           clk = 1'b0;
   logic           rst, x, en, clr, mode;
   logic [W-1:0]   pat;
   logic           f, f_sat;
   logic [SW-1:0]  s, s_sat;
   logic [CW-1:0]  cnt;
   logic [CWS-1:0] cnt_sat;

   int n_chk = 0;
   int n_err = 0;

   bit q[$];
   int exp_s;
   bit exp_f;
   int exp_cnt;

   always #5 clk = ~clk;

   seq_detector_n #(.W(W), .CW(CW)) u_dut (
      .CLK(clk), .RESET(rst), .x(x), .EN(en), .CLR(clr), .MODE(mode),
      .PAT(pat), .F(f), .S(s), .COUNT(cnt)
   );

   seq_detector_n #(.W(W), .CW(CWS)) u_sat (
      .CLK(clk), .RESET(rst), .x(x), .EN(en), .CLR(clr), .MODE(mode),
      .PAT(pat), .F(f_sat), .S(s_sat), .COUNT(cnt_sat)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Model: queue of bits received since the last restart, trimmed to W.
   task automatic model_step(input bit b_rst, input bit b_clr, input bit b_en,
                             input bit b_x, input bit b_mode);
      bit ok;
      if (b_rst) begin
         q.delete();
         exp_s = 0; exp_f = 0; exp_cnt = 0;
      end else if (b_clr) begin
         q.delete();
         exp_s = 0; exp_f = 0;
      end else if (b_en) begin
         q.push_back(b_x);
         if (q.size() > W) void'(q.pop_front());
         exp_s = 0;
         for (int k = 1; k <= q.size(); k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
               if (q[q.size() - k + j] != pat[W-1-j]) ok = 1'b0;
            if (ok) exp_s = k;
         end
         exp_f = (exp_s == W);
         if (exp_f) begin
            exp_cnt++;
            if (!b_mode) q.delete();
         end
      end else begin
         exp_f = 0;
      end
   endtask

   task automatic step(input bit b_x, input bit b_en, input bit b_clr, input bit b_rst);
      @(negedge clk);
      x = b_x; en = b_en; clr = b_clr; rst = b_rst;
      model_step(b_rst, b_clr, b_en, b_x, mode);
      @(posedge clk);
      #1;
      chk("F", f, exp_f);
      chk("S", s, exp_s);
      chk("COUNT", cnt, (exp_cnt > 255) ? 255 : exp_cnt);
      chk("F_sat", f_sat, exp_f);
      chk("S_sat", s_sat, exp_s);
      chk("COUNT_sat", cnt_sat, (exp_cnt > 3) ? 3 : exp_cnt);
   endtask

   initial begin
      bit t_bits[7] = '{1, 0, 1, 1, 0, 1, 1};
      int t1_s[7]   = '{1, 2, 3, 4, 2, 3, 4};
      int t2_s[7]   = '{1, 2, 3, 4, 0, 1, 1};
      bit t6_bits[4] = '{1, 0, 1, 1};

      rst = 1'b1; x = 1'b0; en = 1'b0; clr = 1'b0; mode = 1'b1; pat = 4'b1011;

      // Reset state
      step(0, 0, 0, 1);
      chk("reset_S", s, 0);
      chk("reset_F", f, 0);
      chk("reset_COUNT", cnt, 0);

      // Overlap stream
      for (int i = 0; i < 7; i++) begin
         step(t_bits[i], 1, 0, 0);
         chk("ovl_S", s, t1_s[i]);
      end
      chk("ovl_COUNT", cnt, 2);

      // Non-overlap stream
      mode = 1'b0;
      step(0, 0, 0, 1);
      for (int i = 0; i < 7; i++) begin
         step(t_bits[i], 1, 0, 0);
         chk("novl_S", s, t2_s[i]);
         chk("novl_F", f, (i == 3) ? 1 : 0);
      end
      chk("novl_COUNT", cnt, 1);

      // Enable gap holds progress
      mode = 1'b1;
      step(0, 0, 0, 1);
      step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0);
         chk("gap_S", s, 3);
         chk("gap_F", f, 0);
      end
      step(1, 1, 0, 0);
      chk("gap_end_S", s, 4);
      chk("gap_end_F", f, 1);

      // Soft clear discards the bit and keeps the count
      step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      chk("clr_S", s, 0);
      chk("clr_COUNT", cnt, 1);
      step(1, 1, 0, 0);
      chk("post_clr_S", s, 1);

      // Saturation on the narrow counter
      @(negedge clk); pat = 4'b1111;
      step(0, 0, 0, 1);
      for (int i = 1; i <= 10; i++) begin
         step(1, 1, 0, 0);
         chk("sat_F", f, (i >= 4) ? 1 : 0);
      end
      chk("sat_COUNT_narrow", cnt_sat, 3);
      chk("sat_COUNT_wide", cnt, 7);

      // Reset mid-stream
      @(negedge clk); pat = 4'b1011;
      step(0, 0, 0, 1);
      step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
      step(1, 1, 0, 1);
      chk("midrst_S", s, 0);
      chk("midrst_COUNT", cnt, 0);
      for (int i = 0; i < 4; i++) step(t6_bits[i], 1, 0, 0);
      chk("midrst_F", f, 1);
      chk("midrst_COUNT_after", cnt, 1);

      // Random stream; PAT changes only alongside a reset with EN low
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            @(negedge clk);
            pat = 4'($urandom_range(0, 15));
            step(0, 0, 0, 1);
         end else begin
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            step(1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 39) == 0,
                 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
